// File: rtl/ram_port_ctrl.sv
// Request controller for one port of a fixed-latency RAM: launches requests,
// tracks reads across the read latency, and returns data through a credited FIFO.
module ram_port_ctrl #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 4,
  parameter int READ_LATENCY  = 2,
  parameter int WRITE_LATENCY = 1,
  parameter int RSP_DEPTH     = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0]    req_wdata,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [DATA_WIDTH-1:0]    rsp_rdata,
  output logic                     ram_en,
  output logic                     ram_we,
  output logic [ADDRESS_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0]    ram_din,
  input  logic [DATA_WIDTH-1:0]    ram_dout
);

  localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CW = $clog2(RSP_DEPTH + 1);
  localparam int OW = $clog2(RSP_DEPTH + READ_LATENCY + 2) + 1;

  // Handshakes: a transfer happens on the rising edge where valid && ready;
  // valid never waits on ready, and req_ready never looks at rsp_ready.
  logic                     req_accept;
  logic                     launch_rd;
  logic [READ_LATENCY-1:0]  rd_pipe;
  logic [WRITE_LATENCY-1:0] hz_valid;
  logic [ADDRESS_WIDTH-1:0] hz_addr [WRITE_LATENCY];
  logic                     hazard;
  logic [OW-1:0]            outstanding;

  logic [DATA_WIDTH-1:0]    mem [RSP_DEPTH];
  logic [PW-1:0]            wr_ptr;
  logic [PW-1:0]            rd_ptr;
  logic [CW-1:0]            count;
  logic [DATA_WIDTH-1:0]    last_rdata;
  logic                     push;
  logic                     pop;
  logic                     full;

  assign req_accept = req_valid && req_ready;
  assign launch_rd  = ram_en && !ram_we;
  assign push       = rd_pipe[READ_LATENCY-1];
  assign rsp_valid  = (count != '0);
  assign pop        = rsp_valid && rsp_ready;
  assign full       = (count == CW'(RSP_DEPTH));
  assign rsp_rdata  = rsp_valid ? mem[rd_ptr] : last_rdata;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Hazard tracker stage 0 mirrors the launch register, so a write blocks
  // same-address reads for exactly WRITE_LATENCY cycles after its accept.
  always_comb begin
    hazard      = 1'b0;
    outstanding = OW'(launch_rd) + OW'(count);
    for (int i = 0; i < WRITE_LATENCY; i++) begin
      if (hz_valid[i] && (hz_addr[i] == req_addr)) hazard = 1'b1;
    end
    for (int i = 0; i < READ_LATENCY; i++) begin
      outstanding = outstanding + OW'(rd_pipe[i]);
    end
    req_ready = req_we || (!hazard && (outstanding < OW'(RSP_DEPTH)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_en   <= 1'b0;
      ram_we   <= 1'b0;
      ram_addr <= '0;
      ram_din  <= '0;
      rd_pipe  <= '0;
      hz_valid <= '0;
      for (int i = 0; i < WRITE_LATENCY; i++) hz_addr[i] <= '0;
    end else begin
      ram_en <= req_accept;
      ram_we <= req_accept && req_we;
      if (req_accept) begin
        ram_addr <= req_addr;
        ram_din  <= req_wdata;
      end
      rd_pipe[0] <= launch_rd;
      for (int i = 1; i < READ_LATENCY; i++) rd_pipe[i] <= rd_pipe[i-1];
      hz_valid[0] <= req_accept && req_we;
      hz_addr[0]  <= req_addr;
      for (int i = 1; i < WRITE_LATENCY; i++) begin
        hz_valid[i] <= hz_valid[i-1];
        hz_addr[i]  <= hz_addr[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= ram_dout;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      last_rdata <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (rsp_valid) last_rdata <= mem[rd_ptr];
    end
  end

  // Credit accounting guarantees a full FIFO is never pushed without a pop.
  always_ff @(posedge clk) begin
    if (rst_n) assert (!(push && full && !pop));
  end

endmodule

// File: tb/tb_ram_port_ctrl.sv
// Directed bench for ram_port_ctrl with a behavioural RAM (RL=2, WL=1),
// a vector table for the basic write/read hazard case and scoreboarded sequences.
module tb_ram_port_ctrl;

  logic       clk;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic       req_we;
  logic [3:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_rdata;
  logic       ram_en;
  logic       ram_we;
  logic [3:0] ram_addr;
  logic [7:0] ram_din;
  logic [7:0] ram_dout;

  ram_port_ctrl #(
    .DATA_WIDTH(8), .ADDRESS_WIDTH(4), .READ_LATENCY(2),
    .WRITE_LATENCY(1), .RSP_DEPTH(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_dout(ram_dout)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // RAM port model: write visible one cycle later, read data on dout RL=2 edges after sampling
  logic [7:0] tmem [16];
  logic [7:0] p0;
  always @(posedge clk) begin
    if (ram_en && ram_we) tmem[ram_addr] <= ram_din;
    p0       <= tmem[ram_addr];
    ram_dout <= p0;
  end

  // scoreboard
  logic [7:0] exp_q[$];
  logic [7:0] exp_mem [16];
  int n_checks = 0;
  int n_pass   = 0;
  int n_rsp    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Inputs are set just after a rising edge; tick samples the handshakes
  // mid-cycle, updates the model and advances to just after the next edge.
  task automatic tick(output logic rd_acc);
    logic [7:0] e;
    #1;
    rd_acc = 1'b0;
    if (req_valid && req_ready) begin
      if (req_we) exp_mem[req_addr] = req_wdata;
      else begin
        exp_q.push_back(exp_mem[req_addr]);
        rd_acc = 1'b1;
      end
    end
    if (rsp_valid && rsp_ready) begin
      n_rsp++;
      check("rsp_pending", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("rsp_data", 32'(rsp_rdata), 32'(e));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    logic a;
    req_valid = 1'b0;
    req_we    = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (exp_q.size() == 0 && !rsp_valid) break;
      tick(a);
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic set_req(input logic v, input logic we, input logic [3:0] a, input logic [7:0] d);
    req_valid = v;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
  endtask

  typedef struct {
    logic       v;
    logic       we;
    logic [3:0] a;
    logic [7:0] d;
    logic       rr;
    logic       e_rdy;
    logic       e_en;
    logic       e_we;
    logic       e_rv;
    logic [7:0] e_rd;
  } vec_t;

  vec_t vecs [9];

  initial begin
    logic acc;
    int   rd_idx;
    int   cyc;
    int   base;
    int   stale;
    int   issued;

    // write 3=A5, read 3 stalls once (WL=1), response 3 cycles after accept
    vecs[0] = '{1'b1, 1'b1, 4'd3, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[1] = '{1'b1, 1'b0, 4'd3, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00};
    vecs[2] = '{1'b1, 1'b0, 4'd3, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[3] = '{1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
    vecs[4] = '{1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[5] = '{1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[6] = '{1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA5};
    vecs[7] = '{1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA5};
    vecs[8] = '{1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA5};

    for (int i = 0; i < 16; i++) exp_mem[i] = 8'h00;
    rst_n     = 1'b0;
    rsp_ready = 1'b0;
    set_req(1'b0, 1'b0, 4'd0, 8'h00);
    #1;
    check("reset_ram_en",    32'(ram_en),    32'd0);
    check("reset_ram_we",    32'(ram_we),    32'd0);
    check("reset_ram_addr",  32'(ram_addr),  32'd0);
    check("reset_ram_din",   32'(ram_din),   32'd0);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_rsp_rdata", 32'(rsp_rdata), 32'd0);
    #11;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 9; i++) begin
      set_req(vecs[i].v, vecs[i].we, vecs[i].a, vecs[i].d);
      rsp_ready = vecs[i].rr;
      #1;
      check($sformatf("vec%0d_req_ready", i), 32'(req_ready), 32'(vecs[i].e_rdy));
      check($sformatf("vec%0d_ram_en", i),    32'(ram_en),    32'(vecs[i].e_en));
      check($sformatf("vec%0d_ram_we", i),    32'(ram_we),    32'(vecs[i].e_we));
      check($sformatf("vec%0d_rsp_valid", i), 32'(rsp_valid), 32'(vecs[i].e_rv));
      check($sformatf("vec%0d_rsp_rdata", i), 32'(rsp_rdata), 32'(vecs[i].e_rd));
      tick(acc);
    end

    // prefill 0..7 = 0x10..0x17, then stream reads with rsp_ready=1.
    // Credit covers launch+pipeline+FIFO, so 8 reads take 9 cycles (one credit bubble).
    rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      set_req(1'b1, 1'b1, 4'(i), 8'(8'h10 + i));
      #1;
      check("t2_wr_ready", 32'(req_ready), 32'd1);
      tick(acc);
    end
    rd_idx = 0;
    cyc    = 0;
    while (rd_idx < 8 && cyc < 20) begin
      set_req(1'b1, 1'b0, 4'(rd_idx), 8'h00);
      #1;
      if (rd_idx < 4) check("t2_rd_ready", 32'(req_ready), 32'd1);
      tick(acc);
      if (acc) rd_idx++;
      cyc++;
    end
    check("t2_read_cycles", 32'(cyc), 32'd9);
    drain();

    // credit limit with rsp_ready=0
    rsp_ready = 1'b0;
    base      = 0;
    for (int i = 0; i < 8; i++) begin
      set_req(1'b1, 1'b0, 4'(base), 8'h00);
      tick(acc);
      if (acc) base++;
    end
    check("t3_reads_accepted", 32'(base), 32'd4);
    #1;
    check("t3_rd_blocked", 32'(req_ready), 32'd0);
    check("t3_fifo_valid", 32'(rsp_valid), 32'd1);
    for (int k = 0; k < 3; k++) begin
      set_req(1'b1, 1'b1, 4'(12 + k), 8'(8'hC0 + k));
      #1;
      check("t3_wr_ready", 32'(req_ready), 32'd1);
      tick(acc);
      check("t3_ram_en",   32'(ram_en),   32'd1);
      check("t3_ram_we",   32'(ram_we),   32'd1);
      check("t3_ram_addr", 32'(ram_addr), 32'(12 + k));
      check("t3_ram_din",  32'(ram_din),  32'(8'hC0 + k));
    end
    set_req(1'b1, 1'b0, 4'd5, 8'h00);
    rsp_ready = 1'b1;
    #1;
    check("t3_pop_cycle_blocked", 32'(req_ready), 32'd0);
    tick(acc);
    rsp_ready = 1'b0;
    #1;
    check("t3_credit_released", 32'(req_ready), 32'd1);
    tick(acc);
    drain();

    // reset with two reads in flight
    rsp_ready = 1'b1;
    set_req(1'b1, 1'b0, 4'd1, 8'h00);
    tick(acc);
    set_req(1'b1, 1'b0, 4'd2, 8'h00);
    tick(acc);
    set_req(1'b0, 1'b0, 4'd0, 8'h00);
    #2;
    rst_n = 1'b0;
    #1;
    check("t4_ram_en",    32'(ram_en),    32'd0);
    check("t4_ram_we",    32'(ram_we),    32'd0);
    check("t4_ram_addr",  32'(ram_addr),  32'd0);
    check("t4_ram_din",   32'(ram_din),   32'd0);
    check("t4_rsp_valid", 32'(rsp_valid), 32'd0);
    check("t4_rsp_rdata", 32'(rsp_rdata), 32'd0);
    exp_q.delete();
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    stale = 0;
    for (int i = 0; i < 6; i++) begin
      if (rsp_valid) stale++;
      tick(acc);
    end
    check("t4_no_stale_rsp", 32'(stale), 32'd0);
    rsp_ready = 1'b0;
    base      = 0;
    for (int i = 0; i < 8; i++) begin
      set_req(1'b1, 1'b0, 4'(base), 8'h00);
      tick(acc);
      if (acc) base++;
    end
    check("t4_full_credit", 32'(base), 32'd4);
    drain();

    // fill the FIFO, then stream 44 reads around the ring with a gappy rsp_ready
    base   = n_rsp;
    issued = 0;
    for (int c = 0; c < 300; c++) begin
      if (issued == 44 && exp_q.size() == 0 && !rsp_valid) break;
      rsp_ready = (c < 6) ? 1'b0 : ((c % 4) != 3);
      set_req(issued < 44, 1'b0, 4'(issued % 8), 8'h00);
      tick(acc);
      if (acc) issued++;
    end
    check("t5_issued", 32'(issued), 32'd44);
    check("t5_responses", 32'(n_rsp - base), 32'd44);
    check("t5_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
